// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter.
package bram_arb_pkg;

  localparam int DEF_RAM_WIDTH = 16;
  localparam int DEF_RAM_DEPTH = 1024;
  localparam int DEF_NUM_REQ   = 4;
  localparam int TAG_IDW       = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester id is carried in binary and decoded to one-hot at the response stage.
  typedef struct packed {
    logic [TAG_IDW-1:0] id;
    logic               is_read;
  } rsp_tag_t;

endpackage

// File: rtl/bram_arb_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module bram_arb_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters.
// Optional burst locking is enabled with macro BRAM_ARB_LOCK_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  localparam int AW       = $clog2(RAM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [RAM_WIDTH-1:0]           rsp_rdata,
  output logic                           wr_en,
  output logic                           rd_en,
  output logic [AW-1:0]                  addr,
  output logic [RAM_WIDTH-1:0]           din,
  input  logic [RAM_WIDTH-1:0]           dout
`ifdef BRAM_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]             req_lock
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   eligible, grant, rsp_vld_d;
  logic                 found, xfer;
  logic [PW-1:0]        gidx;
  rsp_tag_t             tag_q [2];
  logic [RAM_WIDTH-1:0] data_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : PW'(int'(i) + 1);
  endfunction

  always_comb begin
    eligible = req_valid;
`ifdef BRAM_ARB_LOCK_EN
    if (state_q == LOCKED) eligible = req_valid & (NUM_REQ'(1) << owner_q);
`endif
  end

  bram_arb_rr_select #(.NUM_REQ(NUM_REQ), .PW(PW)) u_select (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  // Reset gates the grant so nothing reaches the BRAM while rst is high.
  assign xfer      = found && !rst;
  assign req_ready = xfer ? grant : '0;
  assign wr_en     = xfer && req_we[gidx];
  assign rd_en     = xfer && !req_we[gidx];
  assign addr      = xfer ? req_addr[gidx*AW +: AW] : '0;
  assign din       = xfer ? req_wdata[gidx*RAM_WIDTH +: RAM_WIDTH] : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          ptr_d = next_ptr(gidx);
`ifdef BRAM_ARB_LOCK_EN
          if (req_lock[gidx]) begin
            state_d = LOCKED;
            owner_d = gidx;
          end
`endif
        end
      end
`ifdef BRAM_ARB_LOCK_EN
      LOCKED: begin
        if (!req_valid[owner_q]) begin
          state_d = ARB;
          ptr_d   = next_ptr(owner_q);
        end else if (xfer) begin
          ptr_d = next_ptr(gidx);
          if (!req_lock[gidx]) state_d = ARB;
        end
      end
`endif
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    rsp_vld_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_vld_d[i] = tag_q[1].is_read && (tag_q[1].id == TAG_IDW'(i));
    end
  end

  // Stage 0 tags the transfer, stage 1 captures dout, then the response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      data_q    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      tag_q[0] <= '{id: TAG_IDW'(gidx), is_read: rd_en};
      tag_q[1] <= tag_q[0];
      if (tag_q[0].is_read) data_q <= dout;
      rsp_valid <= rsp_vld_d;
      if (tag_q[1].is_read) rsp_rdata <= data_q;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural BRAM and response scoreboard.
module tb_bram_port_arbiter;

  localparam int W  = 16;
  localparam int D  = 1024;
  localparam int N  = 4;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [W-1:0]    rsp_rdata, din, dout;
  logic            wr_en, rd_en;
  logic [AW-1:0]   addr;
`ifdef BRAM_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  typedef struct {
    int          due;
    int          id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] ram [D];
  logic [W-1:0] shadow [D];
  logic [W-1:0] last_rd;
  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (wr_en) ram[addr] <= din;
    if (rd_en) dout <= ram[addr];
  end

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .din       (din),
    .dout      (dout)
`ifdef BRAM_ARB_LOCK_EN
    ,
    .req_lock  (req_lock)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Response monitor: each scoreboard entry must appear on exactly its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) last_rd = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
      chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
      last_rd = e.data;
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
      chk("rdata_hold", 32'(rsp_rdata), 32'(last_rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
`ifdef BRAM_ARB_LOCK_EN
    req_lock  = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*W +: W]   = d;
  endtask

  task automatic wr1(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    clr();
    set_req(i, 1'b1, a, d);
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'(1) << i);
    chk("wr_en", 32'(wr_en), 32'd1);
    chk("wr_addr", 32'(addr), 32'(a));
    chk("wr_din", 32'(din), 32'(d));
    shadow[a] = d;
    tick();
  endtask

  task automatic rd1(input int i, input logic [AW-1:0] a, input bit expect_rsp);
    clr();
    set_req(i, 1'b0, a, '0);
    @(negedge clk);
    chk("rd_ready", 32'(req_ready), 32'(1) << i);
    chk("rd_en", 32'(rd_en), 32'd1);
    chk("rd_addr", 32'(addr), 32'(a));
    if (expect_rsp) sb.push_back('{due: cyc + 3, id: i, data: shadow[a]});
    tick();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clr();
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(16 + i), W'(16'h1000 + i));
    repeat (2) begin
      @(negedge clk);
      chk_quiet("reset");
      chk("reset_rdata", 32'(rsp_rdata), 32'd0);
    end
    tick();
    rst = 1'b0;

    // Scenario 1: all valid, grants rotate without an idle cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rotate", 32'(req_ready), 32'(1) << (k % N));
      chk("rotate_wr", 32'(wr_en), 32'd1);
      tick();
    end
    clr();
    @(negedge clk);
    chk_quiet("idle");
    tick();

    // Scenario 2: write then read of the same address by different requesters.
    wr1(1, AW'(5), 16'habcd);
    rd1(2, AW'(5), 1'b1);
    clr();
    repeat (4) tick();

    // Scenario 3: pipelined reads from four requesters on consecutive cycles.
    for (int i = 0; i < N; i++) wr1(0, AW'(40 + i), W'(16'h3000 + i * 16'h0111));
    for (int i = 0; i < N; i++) rd1(i, AW'(40 + i), 1'b1);
    clr();
    repeat (5) tick();

    // Scenario 5: reset while a read is in flight discards its response.
    rd1(1, AW'(40), 1'b0);
    clr();
    tick();
    rst = 1'b1;
    set_req(1, 1'b1, AW'(70), 16'h7777);
    set_req(3, 1'b1, AW'(71), 16'h8888);
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst2");
      chk("rst2_rdata", 32'(rsp_rdata), 32'd0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'b0010);
    tick();
    clr();

`ifdef BRAM_ARB_LOCK_EN
    // Scenario 4: requester 3 holds the port through a locked burst.
    set_req(0, 1'b1, AW'(80), 16'h0a0a);
    for (int k = 0; k < 5; k++) begin
      set_req(3, 1'b1, AW'(60 + k), W'(16'h6000 + k));
      req_lock[3] = (k < 4);
      @(negedge clk);
      chk("lock_grant", 32'(req_ready), 32'b1000);
      tick();
    end
    req_lock[3] = 1'b0;
    @(negedge clk);
    chk("unlock_grant", 32'(req_ready), 32'b0001);
    tick();
    clr();
`endif

    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
